// File: rtl/tlb_maint_if.sv
// Commit-stage request/response channel of the TLB maintenance sequencer.
interface tlb_maint_if #(
  parameter int IW = 5
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic [2:0]    req_op_i;
  logic [4:0]    req_inv_op_i;
  logic [9:0]    req_asid_i;
  logic [18:0]   req_vpn_i;
  logic          flush_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [2:0]    rsp_op_o;
  logic          rsp_found_o;
  logic [IW-1:0] rsp_idx_o;
  logic          rsp_illegal_o;
  logic          rsp_refetch_o;

  modport master (
    output req_valid_i, req_op_i, req_inv_op_i, req_asid_i, req_vpn_i, flush_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_op_o, rsp_found_o, rsp_idx_o, rsp_illegal_o, rsp_refetch_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_inv_op_i, req_asid_i, req_vpn_i, flush_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_op_o, rsp_found_o, rsp_idx_o, rsp_illegal_o, rsp_refetch_o
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: one op at a time, single-cycle MMU enables, translation hold while a
// mutation settles. Define TLB_FILL_LFSR_EN for an LFSR TLBFILL index instead of a round-robin counter.
module tlb_maint_ctrl #(
  parameter  int         TLB_ENTRY_NUM = 32,
  parameter  int         SETTLE_CYCLES = 2,
  parameter  logic [4:0] LFSR_SEED     = 5'h1F,
  localparam int         IW            = $clog2(TLB_ENTRY_NUM)
) (
  input  logic          clk,
  input  logic          a_rst_n,
  tlb_maint_if.slave    bus,
  output logic          tlbsrch_en_o,
  output logic          tlbrd_en_o,
  output logic          tlbwr_en_o,
  output logic          tlbfill_en_o,
  output logic          invtlb_en_o,
  input  logic          tlbsrch_found_i,
  input  logic [IW-1:0] tlbsrch_idx_i,
  output logic [IW-1:0] rand_idx_o,
  output logic [4:0]    invtlb_op_o,
  output logic [9:0]    invtlb_asid_o,
  output logic [18:0]   invtlb_vpn_o,
  output logic          trans_hold_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (LFSR_SEED == 5'd0 || SETTLE_CYCLES < 1) begin : g_bad_param
    $error("tlb_maint_ctrl: LFSR_SEED must be nonzero and SETTLE_CYCLES >= 1");
  end

  logic [2:0]    r_state;
  logic [2:0]    r_op;
  logic [4:0]    r_inv_op;
  logic [9:0]    r_asid;
  logic [18:0]   r_vpn;
  logic [CW-1:0] r_cnt;
  logic          r_found;
  logic [IW-1:0] r_idx;

  logic w_accept, w_issue, w_resp, w_mut, w_ill, w_srch;

  assign bus.req_ready_o = (r_state == S_IDLE) & ~bus.flush_i;
  assign w_accept = bus.req_valid_i & bus.req_ready_o;
  assign w_issue  = (r_state == S_ISSUE);
  assign w_resp   = (r_state == S_RESP);
  assign w_mut    = (r_op == OP_WR) | (r_op == OP_FILL) | (r_op == OP_INV);
  assign w_ill    = (r_op > OP_INV);
  assign w_srch   = (r_op == OP_SRCH);

  // Flush is honoured only before accept and while the response waits; once
  // the enable has fired the MMU side effect is committed and must complete.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_found <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= bus.req_op_i;
          r_found <= 1'b0;
          r_idx   <= '0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_ill) begin
            r_state <= S_RESP;
          end else if (w_mut) begin
            r_cnt   <= CW'(SETTLE_CYCLES - 1);
            r_state <= S_SETTLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_found <= tlbsrch_found_i;
          r_idx   <= tlbsrch_idx_i;
          r_state <= S_RESP;
        end
        S_SETTLE: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_RESP: if (bus.rsp_ready_i || bus.flush_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_inv_op <= '0;
      r_asid   <= '0;
      r_vpn    <= '0;
    end else if (w_accept) begin
      r_inv_op <= bus.req_inv_op_i;
      r_asid   <= bus.req_asid_i;
      r_vpn    <= bus.req_vpn_i;
    end
  end

  assign tlbsrch_en_o  = w_issue & (r_op == OP_SRCH);
  assign tlbrd_en_o    = w_issue & (r_op == OP_RD);
  assign tlbwr_en_o    = w_issue & (r_op == OP_WR);
  assign tlbfill_en_o  = w_issue & (r_op == OP_FILL);
  assign invtlb_en_o   = w_issue & (r_op == OP_INV);
  assign trans_hold_o  = (w_issue | (r_state == S_SETTLE)) & w_mut;

  assign invtlb_op_o   = r_inv_op;
  assign invtlb_asid_o = r_asid;
  assign invtlb_vpn_o  = r_vpn;

  // Response fields read zero outside RESP; search result only meaningful for SRCH.
  assign bus.rsp_valid_o   = w_resp;
  assign bus.rsp_op_o      = w_resp ? r_op : 3'd0;
  assign bus.rsp_found_o   = w_resp & w_srch & r_found;
  assign bus.rsp_idx_o     = (w_resp & w_srch) ? r_idx : '0;
  assign bus.rsp_illegal_o = w_resp & w_ill;
  assign bus.rsp_refetch_o = w_resp & w_mut;

`ifdef TLB_FILL_LFSR_EN
  logic [4:0] r_lfsr;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  end

  assign rand_idx_o = IW'(r_lfsr);
`else
  logic [IW-1:0] r_rand;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_rand <= '0;
    end else if (w_issue && r_op == OP_FILL) begin
      r_rand <= (r_rand == IW'(TLB_ENTRY_NUM - 1)) ? '0 : r_rand + IW'(1);
    end
  end

  assign rand_idx_o = r_rand;
`endif

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: expected responses queued at issue, compared while held.
module tb_tlb_maint_ctrl;
  localparam int N  = 32;
  localparam int IW = 5;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic a_rst_n;
  always #5 clk = ~clk;

  tlb_maint_if #(.IW(IW)) bus();

  logic          srch_en, rd_en, wr_en, fill_en, inv_en, hold, found;
  logic [IW-1:0] sidx, rand_idx;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid;
  logic [18:0]   inv_vpn;
  logic [4:0]    en;

  assign en = {inv_en, fill_en, wr_en, rd_en, srch_en};

  tlb_maint_ctrl #(.TLB_ENTRY_NUM(N), .SETTLE_CYCLES(SC), .LFSR_SEED(5'h1F)) dut (
    .clk             (clk),
    .a_rst_n         (a_rst_n),
    .bus             (bus),
    .tlbsrch_en_o    (srch_en),
    .tlbrd_en_o      (rd_en),
    .tlbwr_en_o      (wr_en),
    .tlbfill_en_o    (fill_en),
    .invtlb_en_o     (inv_en),
    .tlbsrch_found_i (found),
    .tlbsrch_idx_i   (sidx),
    .rand_idx_o      (rand_idx),
    .invtlb_op_o     (inv_op),
    .invtlb_asid_o   (inv_asid),
    .invtlb_vpn_o    (inv_vpn),
    .trans_hold_o    (hold)
  );

  typedef struct packed {
    logic [2:0]    op;
    logic          found;
    logic [IW-1:0] idx;
    logic          ill;
    logic          rf;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_rand = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rsp_t cur_rsp();
    return {bus.rsp_op_o, bus.rsp_found_o, bus.rsp_idx_o, bus.rsp_illegal_o, bus.rsp_refetch_o};
  endfunction

  // One full op: accept, per-cycle checks of enables/hold/fields, then consume or flush the response.
  task automatic run_op(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid,
                        input logic [18:0] vpn, input logic fnd, input logic [IW-1:0] fidx,
                        input int stall, input bit flush_rsp);
    rsp_t e;
    int   lat;
    bit   mut;
    mut     = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    e.op    = op;
    e.found = (op == 3'd0) ? fnd : 1'b0;
    e.idx   = (op == 3'd0) ? fidx : '0;
    e.ill   = (op > 3'd4);
    e.rf    = mut;
    sb.push_back(e);
    lat = (op <= 3'd1) ? 3 : (mut ? 2 + SC : 2);

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready_o, 1);
    bus.req_valid_i  = 1'b1;
    bus.req_op_i     = op;
    bus.req_inv_op_i = iop;
    bus.req_asid_i   = asid;
    bus.req_vpn_i    = vpn;
    @(negedge clk);
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 3'd7;
    bus.req_inv_op_i = '0;
    bus.req_asid_i   = '0;
    bus.req_vpn_i    = '0;

    for (int k = 1; k <= lat + stall; k++) begin
      if (k > 1) @(negedge clk);
      chk("en_pulse", en, (k == 1 && op <= 3'd4) ? 32'(1 << op) : 32'd0);
      chk("trans_hold", hold, (mut && k <= SC + 1) ? 1 : 0);
      chk("invtlb_fields", {inv_op, inv_asid, inv_vpn}, {iop, asid, vpn});
`ifndef TLB_FILL_LFSR_EN
      if (op == 3'd3 && k == 1) begin
        chk("fill_idx", rand_idx, m_rand);
        m_rand = (m_rand == N - 1) ? 0 : m_rand + 1;
      end
`endif
      if (k == 2) begin found = fnd;  sidx = fidx;  end
      else        begin found = ~fnd; sidx = ~fidx; end
      chk("rsp_valid", bus.rsp_valid_o, (k >= lat) ? 1 : 0);
      if (k >= lat) begin
        chk("req_ready_busy", bus.req_ready_o, 0);
        if (sb.size() > 0) chk("rsp_fields", cur_rsp(), sb[0]);
        else               chk("sb_empty", 1, 0);
      end
    end

    if (flush_rsp) bus.flush_i     = 1'b1;
    else           bus.rsp_ready_i = 1'b1;
    if (sb.size() > 0) e = sb.pop_front();
    @(negedge clk);
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = 1'b0;
    chk("rsp_done", bus.rsp_valid_o, 0);
    chk("en_after", en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n          = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = '0;
    bus.req_inv_op_i = '0;
    bus.req_asid_i   = '0;
    bus.req_vpn_i    = '0;
    bus.flush_i      = 1'b0;
    bus.rsp_ready_i  = 1'b0;
    found            = 1'b0;
    sidx             = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_en", en, 0);
    chk("rst_hold", hold, 0);
    chk("rst_rsp", {bus.rsp_valid_o, cur_rsp()}, 0);
    chk("rst_invtlb", {inv_op, inv_asid, inv_vpn}, 0);
`ifdef TLB_FILL_LFSR_EN
    chk("lfsr_seed", rand_idx, 5'h1F);
    a_rst_n = 1'b1;
    @(negedge clk); chk("lfsr_1", rand_idx, 5'h1E);
    @(negedge clk); chk("lfsr_2", rand_idx, 5'h1C);
`else
    chk("rst_rand", rand_idx, 0);
    a_rst_n = 1'b1;
`endif

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    bus.flush_i = 1'b1; bus.req_valid_i = 1'b1; bus.req_op_i = 3'd0;
    #1 chk("flush_idle_ready", bus.req_ready_o, 0);
    @(negedge clk);
    chk("flush_idle_en", en, 0);
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_idle_en2", en, 0);

    run_op(3'd0, 5'd0, 10'd0, 19'd0, 1'b1, 5'd7, 0, 1'b0);
    run_op(3'd2, 5'd3, 10'h155, 19'h7ABCD, 1'b0, 5'd0, 3, 1'b0);
    run_op(3'd4, 5'd5, 10'h2A, 19'h12345, 1'b0, 5'd0, 0, 1'b0);
    run_op(3'd1, 5'd1, 10'h3FF, 19'h1, 1'b1, 5'd9, 1, 1'b0);
    run_op(3'd6, 5'd2, 10'h11, 19'h22, 1'b1, 5'd3, 1, 1'b0);
    run_op(3'd0, 5'd0, 10'd0, 19'd0, 1'b0, 5'd12, 1, 1'b1);
    for (int i = 0; i < 33; i++)
      run_op(3'd3, 5'(i), 10'(i * 3), 19'(i * 7), 1'b0, 5'd0, 0, 1'b0);

    // Async reset in the middle of a WR settle.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = 3'd2;
    bus.req_inv_op_i = 5'd9; bus.req_asid_i = 10'h1; bus.req_vpn_i = 19'h2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("settle_hold", hold, 1);
    a_rst_n = 1'b0;
    #1;
    chk("arst_hold", hold, 0);
    chk("arst_en", en, 0);
    chk("arst_rsp", {bus.rsp_valid_o, cur_rsp()}, 0);
    chk("arst_invtlb", {inv_op, inv_asid, inv_vpn}, 0);
`ifndef TLB_FILL_LFSR_EN
    chk("arst_rand", rand_idx, 0);
    m_rand = 0;
`endif
    @(negedge clk);
    a_rst_n = 1'b1;
    #1 chk("arst_ready", bus.req_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_reissue", {en, hold, bus.rsp_valid_o}, 0);
    end

    run_op(3'd0, 5'd0, 10'd0, 19'd0, 1'b1, 5'd31, 0, 1'b0);
    run_op(3'd3, 5'd1, 10'd2, 19'd3, 1'b0, 5'd0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tlb_maint_ctrl.md
# tlb_maint_ctrl

Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued at commit. It accepts one operation at a time over a valid/ready handshake and drives single-cycle enable pulses into the memory management unit's TLB maintenance ports. It supplies the TLBFILL replacement index and holds address translation while a TLB write or invalidate settles. It then returns a response to the commit stage, including a refetch request after any TLB mutation.

## Interface
- `TLB_ENTRY_NUM`, 32, TLB entries; index width `IW = $clog2(TLB_ENTRY_NUM)`.
- `SETTLE_CYCLES`, 2, post-mutation hold cycles (≥1).
- `LFSR_SEED`, 5'h1F, reset value of the replacement LFSR; must be nonzero.

Ports:
- `clk` in 1: clock.
- `a_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid_i` in 1: operation request.
- `req_ready_o` out 1: block can accept.
- `req_op_i` in 3: 0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, 5–7 illegal.
- `req_inv_op_i` in 5: INVTLB op field.
- `req_asid_i` in 10: INVTLB asid.
- `req_vpn_i` in 19: INVTLB vpn.
- `flush_i` in 1: pipeline flush.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: response consumed.
- `rsp_op_o` out 3: op being responded to.
- `rsp_found_o` out 1: SRCH hit.
- `rsp_idx_o` out IW: SRCH hit index.
- `rsp_illegal_o` out 1: op code was 5–7.
- `rsp_refetch_o` out 1: refetch after a WR, FILL or INV.
- `tlbsrch_en_o`, `tlbrd_en_o`, `tlbwr_en_o`, `tlbfill_en_o`, `invtlb_en_o` out 1 each: MMU enables.
- `tlbsrch_found_i` in 1 and `tlbsrch_idx_i` in IW: MMU search result.
- `rand_idx_o` out IW: TLBFILL index.
- `invtlb_op_o` out 5, `invtlb_asid_o` out 10, `invtlb_vpn_o` out 19: registered INVTLB fields.
- `trans_hold_o` out 1: stall MMU address-translation requests.

## Operation
- FSM states: IDLE, ISSUE, WAIT, SETTLE, RESP.
- IDLE:
  - `req_ready_o` is 1 only in IDLE and only when `flush_i` is 0.
  - On handshake, latch op and INVTLB fields, then go to ISSUE.
- ISSUE:
  - Exactly one enable is high for this single cycle, selected by the latched op.
  - SRCH and RD go to WAIT.
  - WR, FILL and INV go to SETTLE with the settle counter loaded to `SETTLE_CYCLES-1`.
  - Illegal ops pulse no enable and go straight to RESP with `rsp_illegal_o`=1.
- WAIT: capture `tlbsrch_found_i`/`tlbsrch_idx_i` (valid for SRCH; RD captures but ignores them), then go to RESP. The TLB read and search latency is one cycle.
- SETTLE: decrement the counter; at 0 go to RESP with `rsp_refetch_o`=1.
- RESP:
  - Hold `rsp_valid_o` and all `rsp_*` fields stable until `rsp_ready_i`, then go to IDLE.
  - `flush_i` in RESP drops the response and returns to IDLE.
  - `flush_i` in ISSUE, WAIT or SETTLE is ignored, because the MMU operation is already committed.
- `trans_hold_o` is high in ISSUE and SETTLE for WR, FILL and INV; it is low otherwise.
- `rand_idx_o` is registered. The value present in the ISSUE cycle of a FILL is the one the MMU uses.
- `invtlb_*_o` hold their latched values from accept until the next accept.

## Timing
- Reset values:
  - State IDLE.
  - All enables, `rsp_*`, `trans_hold_o` and `invtlb_*_o` are 0.
  - `req_ready_o` is 1, subject to `flush_i`.
  - Replacement generator is reset per Configuration.
- Accept at cycle T: enable pulse at T+1.
  - SRCH/RD: `rsp_valid_o` first high at T+3.
  - WR/FILL/INV: `rsp_valid_o` first high at T+2+`SETTLE_CYCLES`.
  - Illegal: `rsp_valid_o` first high at T+2.
- A new accept is possible no earlier than the cycle after the response handshake. Throughput is one op per 4 cycles minimum for SRCH.
- Reset asserted mid-operation aborts immediately. No enable is re-issued after release.

## Configuration
- `TLB_FILL_LFSR_EN` defined:
  - `rand_idx_o` comes from a 5-bit LFSR, next = {lfsr[3:0], lfsr[4]^lfsr[2]}, advancing every cycle.
  - Reset value is `LFSR_SEED`; the sequence never reaches 0 (period 31).
  - Index = low IW bits.
- Undefined:
  - `rand_idx_o` is an IW-bit counter, reset 0.
  - It increments by 1 in the cycle after each FILL ISSUE and wraps from `TLB_ENTRY_NUM-1` to 0.

## Test plan
- SRCH accepted at T:
  - `tlbsrch_en_o`=1 only at T+1.
  - Drive found=1, idx=7 at T+2 → `rsp_valid_o` at T+3 with found=1, idx=7, refetch=0, `trans_hold_o` never high.
- WR with `SETTLE_CYCLES`=2, accept at T:
  - `tlbwr_en_o` at T+1.
  - `trans_hold_o` high T+1..T+3.
  - Response at T+4 with refetch=1.
  - `rsp_ready_i` held 0 for 3 cycles → all `rsp_*` stable, `req_ready_o`=0.
- INV op=5, asid=0x2A, vpn=0x12345: `invtlb_*_o` carry these values in the pulse cycle; `invtlb_en_o` is high for exactly 1 cycle.
- Macro off, 33 FILLs: `rand_idx_o` sampled at ISSUE reads 0, 1, …, 31, 0. Macro on, seed 0x1F: first three reset-relative values are 0x1F, 0x1E, 0x1C.
- Flush cases:
  - `flush_i` during RESP → `rsp_valid_o` drops next cycle and state returns to IDLE.
  - `flush_i` with `req_valid_i` in IDLE → no accept.
- Illegal op 6 → no enable pulses, response at T+2 with illegal=1.
- Reset asserted during SETTLE → all outputs return to 0 asynchronously; after release, `req_ready_o`=1.
